aes_inv_sbox_iter: RTL and testbench
====================================

// Module: aes_inv_sbox_iter
// PURPOSE
//  Iterative AES inverse S-box engine; undoes the forward S-box iteration engine.
//  Accepts one byte plus a round count, applies InvSbox (rounds+1) times through one
//  registered feedback loop, and returns the result on a valid/ready output.
//  Used as the decryption-side counterpart in our S-box test designs.
// PARAMETERS
//  CNT_W   4   round-count width; iterations = in_rounds+1, range 1..2**CNT_W
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      reset, asynchronous, active-low (0 = reset)
//  in_valid   in   1      input byte/count presented
//  in_ready   out  1      engine can accept (IDLE only)
//  in_data    in   8      byte to invert
//  in_rounds  in   CNT_W  iterations minus one
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  out_data   out  8      result byte, = data register
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async, any state incl. mid-run): state=IDLE, data_q=8'h00,
//   cnt_q=0, out_valid=0, busy=0; in_ready=1 from the first edge after rst=1.
//  FSM states IDLE, RUN, DONE:
//   IDLE: in_ready=1. in_valid=1 -> data_q<=in_data, cnt_q<=in_rounds, ->RUN.
//   RUN : data_q<=InvSbox(data_q); cnt_q==0 -> DONE, else cnt_q<=cnt_q-1.
//   DONE: out_valid=1, out_data=data_q held stable; out_ready=1 -> IDLE.
//  Latency: accept edge + (in_rounds+1) RUN edges; out_valid rises after the last
//   RUN edge. in_rounds=0 -> exactly one InvSbox; all-ones -> 2**CNT_W iterations.
//  Handshake: no overlap; in_ready=0 in RUN/DONE, in_valid ignored there.
//   out_valid never drops without out_ready. Back-to-back: out_ready in DONE
//   returns to IDLE; next accept one cycle later (2-cycle minimum gap).
//  Counter: down-counter, no wrap; compares to 0 before decrement.
//  out_data is the register only (no combinational path from in_data).
//  X on in_data/in_rounds when in_valid=0 must not affect state.
// STRUCTURE
//  Shared include: FSM state encodings (2 bits: IDLE=0, RUN=1, DONE=2) and CNT_W default.
//  Sub-module aes_inv_sbox: combinational 8->8 InvSbox table (x -> y), instantiated
//   once in the feedback path; 256-entry case, FIPS-197 inverse table.
//  Top: FSM, data_q, cnt_q, handshake logic.
// TESTING
//  1 reset: rst=0 mid-RUN -> out_valid=0, busy=0, out_data=00 immediately; in_ready=1 after release.
//  2 single: in_data=63, in_rounds=0 -> out_data=00 after 1 RUN edge; in_data=ED -> 53.
//  3 multi: in_data=FB, in_rounds=1 -> FB->63->00, out_valid after 2 RUN edges.
//  4 backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid=1, out_data
//    stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
//  5 max count: in_rounds=F, in_data=00 -> 16 RUN edges; result equals golden model.
//  6 roundtrip: random byte b, k=0..15: feed forward-Sbox^(k+1)(b) with in_rounds=k -> out_data=b.

Source files
------------

// File: rtl/aes_inv_sbox_iter_pkg.sv
// Shared definitions for the iterative inverse S-box engine.
package aes_inv_sbox_iter_pkg;

   // Default round-count width: up to 16 iterations per request.
   localparam int CNT_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box (FIPS-197 inverse table), x -> y.
module aes_inv_sbox (
   input  logic [7:0] x,
   output logic [7:0] y
);

   // Full 256-entry lookup; default kept only so y is always assigned.
   always_comb begin
      y = 8'h00;
      case (x)
         8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5; 8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
         8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e; 8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
         8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82; 8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
         8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44; 8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
         8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32; 8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
         8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b; 8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
         8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66; 8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
         8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49; 8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
         8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64; 8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
         8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc; 8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
         8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50; 8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
         8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57; 8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
         8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00; 8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
         8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05; 8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
         8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f; 8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
         8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03; 8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
         8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41; 8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
         8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce; 8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
         8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22; 8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
         8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8; 8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
         8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71; 8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
         8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e; 8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
         8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b; 8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
         8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe; 8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
         8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33; 8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
         8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59; 8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
         8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9; 8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
         8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f; 8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
         8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d; 8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
         8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c; 8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
         8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e; 8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
         8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63; 8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
         default: y = 8'h00;
      endcase
   end

endmodule

// File: rtl/aes_inv_sbox_iter.sv
// Iterative inverse S-box engine: accept a byte, apply InvSbox (rounds+1)
// times through one registered loop, present the result on valid/ready.
module aes_inv_sbox_iter
   import aes_inv_sbox_iter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic [CNT_W-1:0] in_rounds,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [7:0]       data_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       inv_data;
   logic             ready_en_q;
   logic             accept;

   // Single S-box in the feedback path; one substitution per RUN cycle.
   aes_inv_sbox u_inv_sbox (
      .x (data_q),
      .y (inv_data)
   );

   // Accept is held off until the first edge after reset release.
   assign in_ready  = ready_en_q && (state_q == IDLE);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = data_q;

   // Ready-enable flag: low during reset, set on the first clock afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ready_en_q <= 1'b0;
      else      ready_en_q <= 1'b1;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state: counter is compared to zero before any decrement.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)        state_d = RUN;
         RUN:     if (cnt_q == '0)   state_d = DONE;
         DONE:    if (out_ready)     state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Datapath: load on accept, substitute and count down while running.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= 8'h00;
         cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               data_q <= in_data;
               cnt_q  <= in_rounds;
            end
            RUN: begin
               data_q <= inv_data;
               if (cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_sbox_iter.sv
// Directed bench for aes_inv_sbox_iter; expectations come from hand-computed
// constants and an independent forward S-box table.
module tb_aes_inv_sbox_iter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic [3:0] in_rounds = 4'h0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Forward AES S-box, byte i at bits [(255-i)*8 +: 8].
   localparam logic [2047:0] FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   aes_inv_sbox_iter #(.CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_rounds (in_rounds),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] fsb(input logic [7:0] x);
      return FWD[(255 - int'(x)) * 8 +: 8];
   endfunction

   // Inverse obtained by searching the forward table.
   function automatic logic [7:0] inv_search(input logic [7:0] y);
      logic [7:0] r = 8'h00;
      for (int i = 0; i < 256; i++)
         if (fsb(8'(i)) == y) r = 8'(i);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Launch one request, wait for the result, check latency and data, drain it.
   task automatic run_op(input string tag, input logic [7:0] d, input logic [3:0] k,
                         input logic [7:0] exp, input bit drain);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_ready"}, 32'(in_ready), 32'd1);
      in_data = d; in_rounds = k; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 8'hxx; in_rounds = 4'hx;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(int'(k) + 1));
      chk({tag, "_data"}, 32'(out_data), 32'(exp));
      if (drain) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk({tag, "_drain"}, 32'({out_valid, busy}), 32'b00);
      end
   endtask

   initial begin
      logic [7:0] b, v, g, held;
      bit ok;

      // Reset state while held.
      #12;
      chk("rst_state", 32'({out_valid, busy, in_ready, out_data}), 32'h0);
      #5 rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", 32'(in_ready), 32'd1);

      // Single iterations.
      run_op("s63", 8'h63, 4'h0, 8'h00, 1'b1);
      run_op("sED", 8'hED, 4'h0, 8'h53, 1'b1);

      // Two iterations: FB -> 63 -> 00.
      run_op("mFB", 8'hFB, 4'h1, 8'h00, 1'b1);

      // Backpressure with a new request presented while in DONE.
      run_op("bp", 8'hFB, 4'h1, 8'h00, 1'b0);
      held = out_data;
      ok = 1'b1;
      in_valid = 1'b1; in_data = 8'h55; in_rounds = 4'h3;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (!(out_valid && out_data == held && !in_ready && busy)) ok = 1'b0;
      end
      in_valid = 1'b0;
      chk("bp_hold", 32'(ok), 32'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release", 32'({out_valid, busy, in_ready}), 32'b001);

      // Max count: 16 inverse substitutions of 00.
      g = 8'h00;
      for (int i = 0; i < 16; i++) g = inv_search(g);
      run_op("max", 8'h00, 4'hF, g, 1'b1);

      // Roundtrip against the forward S-box for every round count.
      for (int k = 0; k < 16; k++) begin
         b = 8'($urandom_range(0, 255));
         v = b;
         for (int j = 0; j <= k; j++) v = fsb(v);
         run_op($sformatf("rt%0d", k), v, 4'(k), b, 1'b1);
      end

      // Asynchronous reset mid-run.
      in_data = 8'hA5; in_rounds = 4'hF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_out", 32'({out_valid, busy, out_data}), 32'h0);
      chk("arst_ready", 32'(in_ready), 32'd0);
      #3 rst = 1'b1;
      @(posedge clk); #1;
      chk("arst_rel", 32'({in_ready, busy}), 32'b10);
      run_op("post", 8'h63, 4'h0, 8'h00, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
